// File: rtl/param_inst_queue.sv
// param_inst_queue: ID-stage instruction queue between fetch and issue.
// Fetch pushes up to FETCH_W thermometer-masked slots per cycle. Issue sees up
// to ISSUE_W oldest slots and retires 0..ISSUE_W of them per cycle. flush_i
// empties the queue. stop_fetch_o is a registered early-stall hint.
//
// Handshake: in_ready_o depends only on the registered occupancy. A packet is
// accepted on a clock edge where in_valid_i and in_ready_o are both high.
// When in_valid_i is high and in_ready_o is low, the packet is ignored and
// fetch must hold it. On the output side, out_valid_o is a thermometer of the
// visible head slots. deq_num_i names how many of them issue consumes at the
// edge. Any request above the visible count is clamped to that count.
module param_inst_queue #(
  parameter int DEPTH       = 16,
  parameter int FETCH_W     = 4,
  parameter int ISSUE_W     = 2,
  parameter int DATA_W      = 128,
  parameter int STOP_THRESH = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           in_valid_i,
  input  logic [FETCH_W-1:0]             in_mask_i,
  input  logic [FETCH_W*DATA_W-1:0]      in_data_p_i,
  output logic                           in_ready_o,
  output logic [ISSUE_W-1:0]             out_valid_o,
  output logic [ISSUE_W*DATA_W-1:0]      out_data_p_o,
  input  logic [$clog2(ISSUE_W+1)-1:0]   deq_num_i,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic                           stop_fetch_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int DEQ_W = $clog2(ISSUE_W + 1);
  localparam int ENQ_W = $clog2(FETCH_W + 1);

  localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] FETCH_P   = PTR_W'(FETCH_W);
  localparam logic [PTR_W-1:0] ISSUE_P   = PTR_W'(ISSUE_W);
  localparam logic [PTR_W-1:0] THRESH_P  = PTR_W'(STOP_THRESH);

  // Pointers carry one wrap bit. Full and empty are then told apart by
  // tail - head alone.
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic              stop_q;

  // Payload storage. Contents are meaningless until written, so it has no reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  count;
  logic [PTR_W-1:0]  free_slots;
  logic [ENQ_W-1:0]  enq_n;
  logic [DEQ_W-1:0]  vis_n;
  logic [DEQ_W-1:0]  deq_eff;
  logic              enq_fire;
  logic [PTR_W-1:0]  enq_add;
  logic [PTR_W-1:0]  deq_add;
  logic [PTR_W-1:0]  count_next;
  logic [IDX_W-1:0]  head_idx;
  logic [IDX_W-1:0]  tail_idx;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  // Occupancy and back-pressure come only from registered pointers. The
  // ready path therefore never loops through the fetch inputs.
  always_comb begin
    count      = tail_q - head_q;
    free_slots = DEPTH_P - count;
    in_ready_o = (free_slots >= FETCH_P);
  end

  // Slot count of the incoming packet. A thermometer mask makes this its length.
  always_comb begin
    enq_n = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      enq_n = enq_n + ENQ_W'(in_mask_i[k]);
    end
  end

  // Clamp the retire request to the slots actually visible this cycle.
  always_comb begin
    vis_n   = (count > ISSUE_P) ? DEQ_W'(ISSUE_W) : DEQ_W'(count);
    deq_eff = (deq_num_i > vis_n) ? vis_n : deq_num_i;
  end

  // Net pointer movement for the coming edge. Narrow counts are
  // zero-extended to pointer width.
  always_comb begin
    enq_fire   = in_valid_i & in_ready_o & rst;
    enq_add    = enq_fire ? PTR_W'(enq_n) : '0;
    deq_add    = PTR_W'(deq_eff);
    count_next = count + enq_add - deq_add;
  end

  // Pointer and stall-hint state. Flush overrides any enqueue or dequeue in
  // the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      stop_q <= 1'b0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      stop_q <= 1'b0;
    end else begin
      head_q <= head_q + deq_add;
      tail_q <= tail_q + enq_add;
      stop_q <= (count_next >= THRESH_P);
    end
  end

  // Write the accepted slots at consecutive entries from the tail. The index
  // wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (enq_fire && !flush_i) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (ENQ_W'(k) < enq_n) begin
          mem_q[tail_idx + IDX_W'(k)] <= in_data_p_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Present the oldest ISSUE_W entries. Slots that are not valid read as zero.
  always_comb begin
    out_valid_o  = '0;
    out_data_p_o = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      out_valid_o[i] = (count > PTR_W'(i));
      if (out_valid_o[i]) begin
        out_data_p_o[i*DATA_W +: DATA_W] = mem_q[head_idx + IDX_W'(i)];
      end
    end
  end

  // Status outputs are derived from the registered occupancy.
  always_comb begin
    count_o      = count;
    full_o       = (count == DEPTH_P);
    empty_o      = (count == '0);
    stop_fetch_o = stop_q;
  end

endmodule
